instr_fetch_stage: RTL

//  Fetch stage of the R/I single-issue CPU, directly upstream of the control decoder.

---
 rtl/instr_fetch_stage_pkg.sv | 27 ++
 rtl/instr_fetch_stage_pc_register.sv | 33 +++
 rtl/instr_fetch_stage.sv | 115 +++++++++++
 3 files changed

// File: rtl/instr_fetch_stage_pkg.sv
// Shared definitions for the fetch stage: IR field positions, fetch state encoding
// and the default PC increment.
package instr_fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam int OP_HI   = 31;
  localparam int OP_LO   = 26;
  localparam int RS_HI   = 25;
  localparam int RS_LO   = 21;
  localparam int RT_HI   = 20;
  localparam int RT_LO   = 16;
  localparam int RD_HI   = 15;
  localparam int RD_LO   = 11;
  localparam int FUNC_HI = 5;
  localparam int FUNC_LO = 0;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;

  localparam int PC_STEP_DEFAULT = 4;

endpackage

// File: rtl/instr_fetch_stage_pc_register.sv
// Program counter with asynchronous reset; a load (redirect) overrides an
// increment (accepted fetch).
module instr_fetch_stage_pc_register #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [PC_W-1:0] load_pc_i,
  input  logic            inc_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_i)
      pc_d = load_pc_i;
    else if (inc_i)
      pc_d = pc_q + PC_W'(PC_STEP);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: issues imem reads at the PC, latches the returned word into the IR
// and presents its fields to decode; branch/jump redirects take priority.
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            dec_ready_i,
  output logic            ir_valid_o,
  output logic [PC_W-1:0] pc_out_o,
  output logic [5:0]      opa_o,
  output logic [5:0]      funca_o,
  output logic [4:0]      rs_o,
  output logic [4:0]      rt_o,
  output logic [4:0]      rd_o,
  output logic [15:0]     imm_o
);

  fetch_state_e    state_q;
  logic [31:0]     ir_q;
  logic [PC_W-1:0] pc_out_q, drain_addr_q, pc;
  logic            ir_valid_q, req_q;
  logic            pc_inc;
  logic [PC_W-1:0] load_pc;

  assign load_pc = redirect_pc_i & ~PC_W'(3);
  assign pc_inc  = (state_q == ST_REQ) && imem_ack_i && !redirect_i;

  instr_fetch_stage_pc_register #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (redirect_i),
    .load_pc_i (load_pc),
    .inc_i     (pc_inc),
    .pc_o      (pc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      ir_q         <= '0;
      pc_out_q     <= '0;
      drain_addr_q <= '0;
      ir_valid_q   <= 1'b0;
      req_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en_i) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (redirect_i) begin
            if (imem_ack_i) begin
              state_q <= en_i ? ST_REQ : ST_IDLE;
              req_q   <= en_i;
            end else begin
              // the outstanding read must finish at its original address
              state_q      <= ST_DRAIN;
              drain_addr_q <= pc;
            end
          end else if (imem_ack_i) begin
            ir_q       <= imem_rdata_i;
            pc_out_q   <= pc;
            ir_valid_q <= 1'b1;
            state_q    <= ST_HOLD;
            req_q      <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (redirect_i || dec_ready_i) begin
            ir_valid_q <= 1'b0;
            state_q    <= en_i ? ST_REQ : ST_IDLE;
            req_q      <= en_i;
          end
        end
        ST_DRAIN: begin
          if (imem_ack_i) begin
            state_q <= en_i ? ST_REQ : ST_IDLE;
            req_q   <= en_i;
          end
        end
      endcase
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = (state_q == ST_DRAIN) ? drain_addr_q : pc;
  assign ir_valid_o  = ir_valid_q;
  assign pc_out_o    = pc_out_q;
  assign opa_o       = ir_q[OP_HI:OP_LO];
  assign funca_o     = ir_q[FUNC_HI:FUNC_LO];
  assign rs_o        = ir_q[RS_HI:RS_LO];
  assign rt_o        = ir_q[RT_HI:RT_LO];
  assign rd_o        = ir_q[RD_HI:RD_LO];
  assign imm_o       = ir_q[IMM_HI:IMM_LO];

endmodule
